// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: soft-start/soft-stop sequencer for the 32-cycle motor PWM.
// Speed code steps by one toward the latched target once every RAMP_PERIODS
// PWM periods, always landing on a period boundary. estop forces an immediate
// stop and a sticky fault that must be cleared before restarting.
module pwm_ramp_ctrl #(
  parameter int RAMP_PERIODS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] target_speed,
  input  logic       target_valid,
  input  logic       estop,
  input  logic       fault_clr,
  output logic [2:0] speed,
  output logic       pwm_hold,
  output logic       busy,
  output logic       at_target,
  output logic       fault
);

  typedef enum logic [2:0] {IDLE, RAMP_UP, RAMP_DOWN, RUN, ESTOP} state_t;

  localparam logic [7:0] LAST_STEP = 8'(RAMP_PERIODS - 1);

  state_t     state, state_nxt;
  logic [2:0] speed_nxt, target_reg, target_nxt;
  logic [4:0] pcnt;
  logic [7:0] step_cnt, step_nxt;
  logic       hold_nxt, fault_nxt, period_end;

  // Last cycle of a running PWM period; speed changes land on the next edge.
  assign period_end = (pcnt == 5'd31) && !pwm_hold;

  // Next-state, next-speed and bookkeeping; estop overrides everything.
  always_comb begin
    state_nxt  = state;
    speed_nxt  = speed;
    target_nxt = target_reg;
    hold_nxt   = pwm_hold;
    fault_nxt  = fault;
    step_nxt   = step_cnt;
    if (estop) begin
      state_nxt  = ESTOP;
      speed_nxt  = 3'd0;
      hold_nxt   = 1'b1;
      target_nxt = 3'd0;
      fault_nxt  = 1'b1;
      step_nxt   = 8'd0;
    end else begin
      if (fault_clr) fault_nxt = 1'b0;
      if (target_valid && state != ESTOP) target_nxt = target_speed;
      case (state)
        IDLE: begin
          speed_nxt = 3'd0;
          hold_nxt  = 1'b1;
          if (target_valid && target_speed != 3'd0) begin
            state_nxt = RAMP_UP;
            hold_nxt  = 1'b0;
            step_nxt  = 8'd0;
          end
        end
        RAMP_UP, RAMP_DOWN: begin
          if (speed == target_reg) begin
            // Arrived: a zero target parks the generator, otherwise hold speed.
            step_nxt = 8'd0;
            if (target_reg == 3'd0) begin
              state_nxt = IDLE;
              hold_nxt  = 1'b1;
            end else begin
              state_nxt = RUN;
            end
          end else if (period_end) begin
            if (step_cnt == LAST_STEP) begin
              // Direction is taken from the current target, so a reversal
              // never steps away from it.
              step_nxt = 8'd0;
              if (target_reg > speed) begin
                speed_nxt = speed + 3'd1;
                state_nxt = RAMP_UP;
              end else begin
                speed_nxt = speed - 3'd1;
                state_nxt = RAMP_DOWN;
              end
            end else begin
              step_nxt = step_cnt + 8'd1;
            end
          end
        end
        RUN: begin
          if (target_valid && target_speed != speed) begin
            state_nxt = (target_speed > speed) ? RAMP_UP : RAMP_DOWN;
            step_nxt  = 8'd0;
          end
        end
        ESTOP: begin
          // Leave only once the fault register itself has been cleared.
          if (!fault) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Datapath registers; busy/at_target are registered from next-state values
  // so they agree with state and speed in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      speed      <= 3'd0;
      pwm_hold   <= 1'b1;
      busy       <= 1'b0;
      at_target  <= 1'b1;
      fault      <= 1'b0;
      target_reg <= 3'd0;
      pcnt       <= 5'd0;
      step_cnt   <= 8'd0;
    end else begin
      speed      <= speed_nxt;
      pwm_hold   <= hold_nxt;
      busy       <= (state_nxt == RAMP_UP) || (state_nxt == RAMP_DOWN);
      at_target  <= (speed_nxt == target_nxt);
      fault      <= fault_nxt;
      target_reg <= target_nxt;
      step_cnt   <= step_nxt;
      // Period counter restarts from 0 when the generator is released.
      pcnt       <= (pwm_hold || hold_nxt) ? 5'd0 : pcnt + 5'd1;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: ramps, reversal, estop/fault, reset.
module tb_pwm_ramp_ctrl;

  logic       clock, reset;
  logic [2:0] target_speed, target_speed1;
  logic       target_valid, target_valid1;
  logic       estop, fault_clr;
  logic [2:0] speed, speed1;
  logic       pwm_hold, busy, at_target, fault;
  logic       pwm_hold1, busy1, at_target1, fault1;

  int checks = 0;
  int failures = 0;
  int t = 0;

  pwm_ramp_ctrl #(.RAMP_PERIODS(4)) dut (
    .clock(clock), .reset(reset), .target_speed(target_speed),
    .target_valid(target_valid), .estop(estop), .fault_clr(fault_clr),
    .speed(speed), .pwm_hold(pwm_hold), .busy(busy),
    .at_target(at_target), .fault(fault)
  );

  pwm_ramp_ctrl #(.RAMP_PERIODS(1)) dut1 (
    .clock(clock), .reset(reset), .target_speed(target_speed1),
    .target_valid(target_valid1), .estop(1'b0), .fault_clr(1'b0),
    .speed(speed1), .pwm_hold(pwm_hold1), .busy(busy1),
    .at_target(at_target1), .fault(fault1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; inputs are driven and outputs sampled on negedges.
  task automatic adv(input int n);
    repeat (n) @(negedge clock);
    t += n;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_speed"}, 32'(speed), 0);
    chk({tag, "_hold"}, 32'(pwm_hold), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_at_target"}, 32'(at_target), 1);
    chk({tag, "_fault"}, 32'(fault), 0);
  endtask

  initial begin
    reset = 1'b1; target_speed = 3'd0; target_valid = 1'b0;
    target_speed1 = 3'd0; target_valid1 = 1'b0; estop = 1'b0; fault_clr = 1'b0;
    adv(3);
    chk_reset_vals("rst");
    reset = 1'b0;
    adv(2);
    chk("idle_hold", 32'(pwm_hold), 1);

    // RAMP_PERIODS=1 instance, target 2: one step every 32 cycles.
    target_speed1 = 3'd2; target_valid1 = 1'b1;
    adv(1); t = 0; target_valid1 = 1'b0;
    chk("rp1_hold", 32'(pwm_hold1), 0);
    adv(31); chk("rp1_t31", 32'(speed1), 0);
    adv(1);  chk("rp1_t32", 32'(speed1), 1);
    adv(31); chk("rp1_t63", 32'(speed1), 1);
    adv(1);  chk("rp1_t64", 32'(speed1), 2);
    adv(1);  chk("rp1_run_busy", 32'(busy1), 0);
    chk("rp1_at_target", 32'(at_target1), 1);

    // Full 0->7 ramp, RAMP_PERIODS=4: step every 128 cycles.
    target_speed = 3'd7; target_valid = 1'b1;
    adv(1); t = 0; target_valid = 1'b0;
    chk("up_hold", 32'(pwm_hold), 0);
    chk("up_busy", 32'(busy), 1);
    chk("up_at_target", 32'(at_target), 0);
    adv(127); chk("up_t127", 32'(speed), 0);
    adv(1);   chk("up_t128", 32'(speed), 1);
    for (int s = 2; s <= 7; s++) begin
      adv(127); chk($sformatf("up_pre%0d", s), 32'(speed), 32'(s - 1));
      adv(1);   chk($sformatf("up_step%0d", s), 32'(speed), 32'(s));
    end
    chk("up_t896_busy", 32'(busy), 1);
    chk("up_t896_at_target", 32'(at_target), 1);
    adv(1);
    chk("run_busy", 32'(busy), 0);
    chk("run_speed", 32'(speed), 7);

    // Ramp down to 0 from RUN; pcnt keeps running so first step is at t=1024.
    target_speed = 3'd0; target_valid = 1'b1;
    adv(1); target_valid = 1'b0;
    chk("dn_busy", 32'(busy), 1);
    adv(1023 - t); chk("dn_t1023", 32'(speed), 7);
    adv(1);        chk("dn_t1024", 32'(speed), 6);
    for (int i = 1; i < 7; i++) begin
      adv(128); chk($sformatf("dn_step%0d", i), 32'(speed), 32'(6 - i));
    end
    chk("dn_zero_hold", 32'(pwm_hold), 0);
    chk("dn_zero_busy", 32'(busy), 1);
    adv(1);
    chk("dn_idle_hold", 32'(pwm_hold), 1);
    chk("dn_idle_busy", 32'(busy), 0);

    // Reversal: ramp toward 7, retarget to 1 at speed 3.
    target_speed = 3'd7; target_valid = 1'b1;
    adv(1); t = 0; target_valid = 1'b0;
    adv(384); chk("rev_t384", 32'(speed), 3);
    adv(6);
    target_speed = 3'd1; target_valid = 1'b1;
    adv(1); target_valid = 1'b0;
    adv(511 - t); chk("rev_t511", 32'(speed), 3);
    adv(1);       chk("rev_t512", 32'(speed), 2);
    adv(127);     chk("rev_t639", 32'(speed), 2);
    adv(1);       chk("rev_t640", 32'(speed), 1);
    chk("rev_t640_busy", 32'(busy), 1);
    adv(1);
    chk("rev_run_busy", 32'(busy), 0);
    chk("rev_run_at_target", 32'(at_target), 1);

    // RUN at 1 -> target 5; pcnt phase carries over, steps at 768..1152.
    target_speed = 3'd5; target_valid = 1'b1;
    adv(1); target_valid = 1'b0;
    adv(767 - t); chk("up5_t767", 32'(speed), 1);
    adv(1);       chk("up5_t768", 32'(speed), 2);
    adv(384);     chk("up5_t1152", 32'(speed), 5);
    adv(1);       chk("up5_run_busy", 32'(busy), 0);

    // estop pulse in RUN at speed 5.
    estop = 1'b1;
    adv(1);
    chk("es_speed", 32'(speed), 0);
    chk("es_hold", 32'(pwm_hold), 1);
    chk("es_fault", 32'(fault), 1);
    chk("es_busy", 32'(busy), 0);
    target_speed = 3'd6; target_valid = 1'b1; fault_clr = 1'b1;
    adv(1); target_valid = 1'b0; fault_clr = 1'b0;
    chk("es_clr_blocked", 32'(fault), 1);
    chk("es_tv_ignored", 32'(at_target), 1);
    estop = 1'b0;
    target_speed = 3'd3; target_valid = 1'b1;
    adv(1); target_valid = 1'b0;
    chk("es_sticky", 32'(fault), 1);
    chk("es_tv_ignored2", 32'(at_target), 1);
    fault_clr = 1'b1;
    adv(1); fault_clr = 1'b0;
    chk("es_cleared", 32'(fault), 0);
    chk("es_cleared_hold", 32'(pwm_hold), 1);
    adv(1);
    chk("es_idle_hold", 32'(pwm_hold), 1);
    chk("es_idle_speed", 32'(speed), 0);

    // Restart from IDLE, then asynchronous reset at speed 4 mid-ramp.
    target_speed = 3'd7; target_valid = 1'b1;
    adv(1); t = 0; target_valid = 1'b0;
    chk("rs_busy", 32'(busy), 1);
    chk("rs_hold", 32'(pwm_hold), 0);
    adv(512);
    chk("rs_t512", 32'(speed), 4);
    #2 reset = 1'b1;
    #1 chk_reset_vals("async_rst");
    adv(2);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
